// File: rtl/clint_tmr_if.sv
// Bus bundle between a core-side master and the CLINT timer block.
// One request per handshake, one registered response per request.
interface clint_tmr_if;
    logic        req_i;
    logic        ready_o;
    logic        we_i;
    logic [15:0] addr_i;
    logic [63:0] wdata_i;
    logic [7:0]  wstrb_i;
    logic        rsp_valid_o;
    logic [63:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i,
        output we_i,
        output addr_i,
        output wdata_i,
        output wstrb_i,
        input  ready_o,
        input  rsp_valid_o,
        input  rdata_o,
        input  err_o
    );

    modport slave (
        input  req_i,
        input  we_i,
        input  addr_i,
        input  wdata_i,
        input  wstrb_i,
        output ready_o,
        output rsp_valid_o,
        output rdata_o,
        output err_o
    );
endinterface

// File: rtl/clint_tmr.sv
// CLINT timer: msip, mtimecmp and a prescaled mtime behind a
// two-state request/response bus, with registered timer interrupt.
module clint_tmr #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    clint_tmr_if.slave  bus,
    output logic        tmr_irq_o,
    output logic        sft_irq_o
);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    localparam logic [12:0] A_MSIP  = 13'h0000;
    localparam logic [12:0] A_CMP   = 13'h0800;
    localparam logic [12:0] A_MTIME = 13'h17FF;
    localparam logic [15:0] DIV_M1  = 16'(TICK_DIV - 1);

    state_t      state_q;
    logic        ready_q;
    logic        rsp_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        msip_q, msip_d;
    logic        irq_q;

    logic        tick;
    logic        accept;
    logic        wr;
    logic [12:0] word;
    logic        hit_msip;
    logic        hit_cmp;
    logic        hit_mtime;
    logic        mapped;
    logic [63:0] bmask;
    logic [63:0] mtime_inc;
    logic [63:0] rd_sel;
    logic        unused_addr;

    assign unused_addr = ^bus.addr_i[2:0];

    always_comb begin
        tick      = (presc_q == DIV_M1);
        presc_d   = tick ? 16'd0 : presc_q + 16'd1;
        accept    = bus.req_i && ready_q;
        wr        = accept && bus.we_i;
        word      = bus.addr_i[15:3];
        hit_msip  = (word == A_MSIP);
        hit_cmp   = (word == A_CMP);
        hit_mtime = (word == A_MTIME);
        mapped    = hit_msip || hit_cmp || hit_mtime;
        for (int i = 0; i < 8; i++) begin
            bmask[i*8 +: 8] = {8{bus.wstrb_i[i]}};
        end
    end

    // A bus write to mtime overrides the tick on the written bytes only.
    always_comb begin
        mtime_inc = mtime_q + 64'(tick);
        mtime_d   = mtime_inc;
        cmp_d     = cmp_q;
        msip_d    = msip_q;
        if (wr && hit_mtime) begin
            mtime_d = (bus.wdata_i & bmask) | (mtime_inc & ~bmask);
        end
        if (wr && hit_cmp) begin
            cmp_d = (bus.wdata_i & bmask) | (cmp_q & ~bmask);
        end
        if (wr && hit_msip && bus.wstrb_i[0]) begin
            msip_d = bus.wdata_i[0];
        end
    end

    always_comb begin
        rd_sel = 64'd0;
        unique case (1'b1)
            hit_msip:  rd_sel = {63'd0, msip_q};
            hit_cmp:   rd_sel = cmp_q;
            hit_mtime: rd_sel = mtime_q;
            default:   rd_sel = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            rsp_q   <= 1'b0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b0;
                        rsp_q   <= 1'b1;
                        rdata_q <= bus.we_i ? 64'd0 : rd_sel;
                        err_q   <= !mapped;
                    end else begin
                        ready_q <= 1'b1;
                        rsp_q   <= 1'b0;
                        rdata_q <= 64'd0;
                        err_q   <= 1'b0;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    rsp_q   <= 1'b0;
                    rdata_q <= 64'd0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    rsp_q   <= 1'b0;
                    rdata_q <= 64'd0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
            cmp_q   <= '1;
            msip_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            msip_q  <= msip_d;
            irq_q   <= (mtime_q >= cmp_q);
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.rsp_valid_o = rsp_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.err_o       = err_q;
    assign tmr_irq_o       = irq_q;
    assign sft_irq_o       = msip_q;

endmodule

// File: doc/clint_tmr.md
CLINT_TMR -- requirements
Module: clint_tmr

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, meaning clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_i, input, 1 bit: bus request valid.
REQ-005 SHALL have port ready_o, output, 1 bit: request accepted when req_i and ready_o are both high.
REQ-006 SHALL have port we_i, input, 1 bit: 1 means write, 0 means read.
REQ-007 SHALL have port addr_i, input, 16 bits: byte offset, 8-byte aligned; addr_i[2:0] ignored.
REQ-008 SHALL have port wdata_i, input, 64 bits: write data.
REQ-009 SHALL have port wstrb_i, input, 8 bits: byte write enables.
REQ-010 SHALL have port rsp_valid_o, output, 1 bit: response valid.
REQ-011 SHALL have port rdata_o, output, 64 bits: read data, qualified by rsp_valid_o.
REQ-012 SHALL have port err_o, output, 1 bit: unmapped access, qualified by rsp_valid_o.
REQ-013 SHALL have port tmr_irq_o, output, 1 bit: timer interrupt, wired to the interrupt controller tmr_irq_i.
REQ-014 SHALL have port sft_irq_o, output, 1 bit: software interrupt (msip[0]).

Function
REQ-015 SHALL map msip at 0x0000 (bit 0 writable, bits 63:1 read 0), mtimecmp at 0x4000 (64 bits), and mtime at 0xBFF8 (64 bits).
REQ-016 SHALL implement a bus FSM with states S_IDLE and S_RESP: S_IDLE drives ready_o=1; acceptance moves to S_RESP; S_RESP drives ready_o=0 and rsp_valid_o=1 for exactly one cycle, then returns to S_IDLE.
REQ-017 SHALL give a response latency of 1 cycle after acceptance, for a peak throughput of one transaction per 2 cycles.
REQ-018 SHALL, on a read, register rdata_o from the register value in the acceptance cycle.
REQ-019 SHALL drive rdata_o=0 whenever rsp_valid_o=0, and on write responses.
REQ-020 SHALL, on a write, update in the acceptance cycle only the bytes whose wstrb_i bit is set; wstrb_i=0 leaves the register unchanged and still gives a normal response.
REQ-021 SHALL, on an unmapped address, ignore the write, return rdata_o=0, and assert err_o=1 with rsp_valid_o.
REQ-022 SHALL use a prescaler counter counting 0..TICK_DIV-1; mtime increments by 1 on the cycle the counter equals TICK_DIV-1, and the counter then wraps to 0.
REQ-023 SHALL increment mtime every cycle when TICK_DIV=1.
REQ-024 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-025 SHALL, when a bus write to mtime coincides with a tick, load the written bytes (write wins) and increment none of them; unwritten bytes take the incremented value.
REQ-026 SHALL drive tmr_irq_o as a register updated every cycle to (mtime >= mtimecmp), unsigned 64-bit compare on current register values, so it lags by 1 cycle.
REQ-027 SHALL deassert tmr_irq_o one cycle after a write makes mtimecmp > mtime.
REQ-028 SHALL drive sft_irq_o directly from msip[0] with no extra delay.
REQ-029 SHALL ignore req_i while in S_RESP; a request held high is accepted in the next S_IDLE.

Reset
REQ-030 SHALL, while rst_n=0 (asynchronously), force: state S_IDLE, ready_o=0, rsp_valid_o=0, rdata_o=0, err_o=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, tmr_irq_o=0, sft_irq_o=0.
REQ-031 SHALL drive ready_o=1 from the first clk edge after rst_n deasserts.
REQ-032 SHALL, when reset is asserted mid-transaction, drop the pending response and never issue it.

Verification
REQ-033 SHALL cover: reset release, TICK_DIV=1, 10 cycles -> read of 0xBFF8 returns 10 (±1 for response timing), err_o=0, tmr_irq_o stays 0.
REQ-034 SHALL cover: write mtimecmp=0x20 with wstrb=0xFF -> tmr_irq_o rises exactly 1 cycle after mtime reaches 0x20; then write mtimecmp=0xFFFF -> tmr_irq_o falls 1 cycle later.
REQ-035 SHALL cover: write mtime=64'hFFFF_FFFF_FFFF_FFFE -> two ticks later mtime=0; while mtimecmp=0, tmr_irq_o stays 1 throughout.
REQ-036 SHALL cover: write 0x1122334455667788 to mtimecmp with wstrb=0x0F over 0xFFFF_FFFF_FFFF_FFFF -> readback 0xFFFF_FFFF_5566_7788.
REQ-037 SHALL cover: write msip=1 -> sft_irq_o=1 the next cycle; read of 0x1234 -> rsp_valid_o=1, err_o=1, rdata_o=0; msip unchanged.
REQ-038 SHALL cover: TICK_DIV=4, write to mtime in the same cycle as a tick -> written value held, incremented 4 cycles later; rst_n pulse in S_RESP -> no rsp_valid_o is issued.
